// File: rtl/asic_chain_config_scheduler_if.sv
// Command-side and chain-side signal bundle for the chain configuration scheduler.
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every request
// and response is a single-cycle pulse sampled on the rising clock edge.
// - ConfigStart is accepted only when the scheduler is idle; otherwise it is dropped.
// - ConfigAbort is acted on in any non-idle cycle and wins over anything else that cycle.
// - ParameterLoadStart and ParameterLoadDone are one-cycle, per-chain pulses.
// - ConfigDone and ConfigAborted are one-cycle completion pulses.
// DbgState mirrors the scheduler FSM state for observation only.
interface asic_chain_config_scheduler_if #(
   parameter int unsigned NUM_CHAINS = 4
) ();
   logic                  ConfigStart;
   logic                  ConfigAbort;
   logic [NUM_CHAINS-1:0] ChainEnableMask;
   logic [NUM_CHAINS-1:0] ParameterLoadDone;
   logic [NUM_CHAINS-1:0] ParameterLoadStart;
   logic [3:0]            AsicChainSelect;
   logic                  Busy;
   logic                  ConfigDone;
   logic                  ConfigAborted;
   logic [NUM_CHAINS-1:0] ChainDoneMask;
   logic [NUM_CHAINS-1:0] ChainErrorMask;
   logic [2:0]            DbgState;

   // Command interpreter / chain engines side
   modport master (
      output ConfigStart, ConfigAbort, ChainEnableMask, ParameterLoadDone,
      input  ParameterLoadStart, AsicChainSelect, Busy, ConfigDone, ConfigAborted,
      input  ChainDoneMask, ChainErrorMask, DbgState
   );

   // Scheduler side
   modport slave (
      input  ConfigStart, ConfigAbort, ChainEnableMask, ParameterLoadDone,
      output ParameterLoadStart, AsicChainSelect, Busy, ConfigDone, ConfigAborted,
      output ChainDoneMask, ChainErrorMask, DbgState
   );
endinterface

// File: rtl/asic_chain_config_scheduler.sv
// Sequences MICROROC slow-control loading across the enabled ASIC chains in ascending
// order: select chain, settle, pulse load start, wait for done or timeout, record status.
module asic_chain_config_scheduler #(
   parameter int unsigned NUM_CHAINS     = 4,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                                Clk,
   input  logic                                reset_n,
   asic_chain_config_scheduler_if.slave        bus
);

   // One counter serves both the settle delay and the done timeout; it saturates.
   localparam int unsigned CNT_LIM = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_LIM + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT, S_FINISH
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            sel_q, sel_d;
   logic [NUM_CHAINS-1:0] pending_q, pending_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_CHAINS-1:0] done_mask_q, done_mask_d;
   logic [NUM_CHAINS-1:0] err_mask_q, err_mask_d;
   logic                  aborted_q, aborted_d;

   logic [3:0]            pick_idx;
   logic [NUM_CHAINS-1:0] pick_oh;
   logic [NUM_CHAINS-1:0] sel_oh;
   logic                  sel_done;
   logic [NUM_CHAINS-1:0] start_vec;
   logic                  cfg_done;

   // Lowest pending chain and one-hot decode of the currently selected chain
   always_comb begin
      pick_idx = '0;
      pick_oh  = '0;
      sel_oh   = '0;
      for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
         if (pending_q[i]) pick_idx = 4'(i);
      end
      for (int i = 0; i < NUM_CHAINS; i++) begin
         pick_oh[i] = (pick_idx == 4'(i));
         sel_oh[i]  = (sel_q == 4'(i));
      end
      // Only the selected chain's done pulse is of interest; others are ignored.
      sel_done = |(bus.ParameterLoadDone & sel_oh);
   end

   // Next-state and pulse outputs; abort overrides everything outside IDLE
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pending_d   = pending_q;
      cnt_d       = cnt_q;
      done_mask_d = done_mask_q;
      err_mask_d  = err_mask_q;
      aborted_d   = 1'b0;
      start_vec   = '0;
      cfg_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ConfigStart) begin
               pending_d   = bus.ChainEnableMask;
               done_mask_d = '0;
               err_mask_d  = '0;
               state_d     = S_SELECT;
            end
         end
         S_SELECT: begin
            if (pending_q == '0) begin
               state_d = S_FINISH;
            end else begin
               sel_d     = pick_idx;
               pending_d = pending_q & ~pick_oh;
               cnt_d     = '0;
               state_d   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = S_START;
            else                                  cnt_d   = cnt_q + 1'b1;
         end
         S_START: begin
            start_vec = sel_oh;
            cnt_d     = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (sel_done) begin
               done_mask_d = done_mask_q | sel_oh;
               state_d     = S_SELECT;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_mask_d = err_mask_q | sel_oh;
               state_d    = S_SELECT;
            end else if (cnt_q != CW'(CNT_LIM)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FINISH: begin
            cfg_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && bus.ConfigAbort) begin
         state_d     = S_IDLE;
         aborted_d   = 1'b1;
         sel_d       = sel_q;
         pending_d   = '0;
         cnt_d       = '0;
         done_mask_d = done_mask_q;
         err_mask_d  = err_mask_q;
         start_vec   = '0;
         cfg_done    = 1'b0;
      end
   end

   // State and status registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         pending_q   <= '0;
         cnt_q       <= '0;
         done_mask_q <= '0;
         err_mask_q  <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         done_mask_q <= done_mask_d;
         err_mask_q  <= err_mask_d;
         aborted_q   <= aborted_d;
      end
   end

   assign bus.ParameterLoadStart = start_vec;
   assign bus.AsicChainSelect    = sel_q;
   assign bus.Busy               = (state_q != S_IDLE);
   assign bus.ConfigDone         = cfg_done;
   assign bus.ConfigAborted      = aborted_q;
   assign bus.ChainDoneMask      = done_mask_q;
   assign bus.ChainErrorMask     = err_mask_q;
   assign bus.DbgState           = state_q;

endmodule
